// File: rtl/memfu_pkg.sv
// Shared types, flag-bit positions and address-region decode for the load/store unit.
package memfu_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_OUT} state_e;
  typedef enum logic [1:0] {REG_RAM, REG_LED, REG_SW} region_e;

  localparam int unsigned FLAG_STORE  = 1;
  localparam int unsigned FLAG_OFFSET = 2;
  localparam int unsigned FLAG_NOCDB  = 7;

  // Switch words sit at sw_base, sw_base-1, ... sw_base-(nsw-1); the LED address wins any overlap.
  function automatic region_e decode_region(input int unsigned addr, input int unsigned led_addr,
                                            input int unsigned sw_base, input int unsigned nsw);
    if (addr == led_addr) return REG_LED;
    if ((addr <= sw_base) && ((sw_base - addr) < nsw)) return REG_SW;
    return REG_RAM;
  endfunction

endpackage

// File: rtl/memfu_ram.sv
// Single-port data RAM with synchronous write and registered read (block-RAM style).
module memfu_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memfu.sv
// Load/store functional unit: one op in flight, RAM plus memory-mapped LED and switches,
// results held on the CDB/ROB handshakes until both are taken.
module memfu
  import memfu_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned ROBID_W  = 4,
  parameter int unsigned SW_W     = 16,
  parameter int unsigned LED_ADDR = (32'd1 << ADDR_W) - 32'd1,
  parameter int unsigned SW_BASE  = (32'd1 << ADDR_W) - 32'd2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_transmit,
  input  logic [DATA_W-1:0]      operand,
  input  logic [1:0][DATA_W-1:0] depvals,
  input  logic [7:0]             wbs,
  input  logic [7:0]             flags,
  input  logic [ROBID_W-1:0]     robid,
  input  logic                   cdb_transmit,
  output logic                   cdb_transmit_out,
  output logic [ROBID_W-1:0]     cdb_id,
  output logic [DATA_W-1:0]      cdb_val,
  input  logic                   rob_transmit,
  output logic                   rob_transmit_out,
  output logic [ROBID_W-1:0]     robid_out,
  output logic [7:0]             flags_out,
  output logic [7:0]             wbs_out,
  output logic [DATA_W-1:0]      value_out,
  output logic                   busy,
  input  logic [SW_W-1:0]        sw,
  output logic [DATA_W-1:0]      led
);

  localparam int unsigned NSW = (SW_W + DATA_W - 1) / DATA_W;

  state_e                  state;
  region_e                 region;
  logic [ADDR_W-1:0]       addr;
  logic [NSW*DATA_W-1:0]   sw_pad;
  logic [DATA_W-1:0]       sw_word;
  logic [DATA_W-1:0]       mmio_val;
  logic [DATA_W-1:0]       ram_rdata;
  logic                    accept;
  logic                    is_store;
  logic                    ram_we;
  logic                    direct;
  logic                    cdb_pend;
  logic                    rob_pend;

  assign addr     = ADDR_W'(depvals[1] + (flags[FLAG_OFFSET] ? operand : DATA_W'(0)));
  assign region   = decode_region(32'(addr), LED_ADDR, SW_BASE, NSW);
  assign accept   = (state == ST_IDLE) && input_transmit;
  assign is_store = flags[FLAG_STORE];
  assign ram_we   = accept && is_store && (region == REG_RAM);
  assign direct   = is_store || (region != REG_RAM);
  assign sw_pad   = (NSW*DATA_W)'(sw);
  assign mmio_val = (region == REG_LED) ? led : sw_word;

  // Switch word k lives at SW_BASE-k.
  always_comb begin
    sw_word = '0;
    for (int unsigned k = 0; k < NSW; k++) begin
      if (k == (SW_BASE - 32'(addr))) sw_word = sw_pad[k*DATA_W +: DATA_W];
    end
  end

  memfu_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr),
    .wdata(depvals[0]),
    .rdata(ram_rdata)
  );

  assign busy             = (state != ST_IDLE);
  assign cdb_transmit_out = cdb_pend;
  assign rob_transmit_out = rob_pend;
  assign cdb_id           = robid_out;
  assign cdb_val          = value_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cdb_pend  <= 1'b0;
      rob_pend  <= 1'b0;
      robid_out <= '0;
      flags_out <= '0;
      wbs_out   <= '0;
      value_out <= '0;
      led       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            robid_out <= robid;
            flags_out <= flags;
            wbs_out   <= wbs;
            if (is_store && (region == REG_LED)) led <= depvals[0];
            if (direct) begin
              value_out <= is_store ? '0 : mmio_val;
              cdb_pend  <= ~flags[FLAG_NOCDB];
              rob_pend  <= 1'b1;
              state     <= ST_OUT;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          value_out <= ram_rdata;
          cdb_pend  <= ~flags_out[FLAG_NOCDB];
          rob_pend  <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          // Leave once nothing remains pending after this edge's grants.
          if (cdb_transmit) cdb_pend <= 1'b0;
          if (rob_transmit) rob_pend <= 1'b0;
          if (!(cdb_pend && !cdb_transmit) && !(rob_pend && !rob_transmit)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memfu.sv
// Directed bench for memfu: RAM/MMIO loads and stores, address wrap, handshake holding, reset abort.
module tb_memfu;

  logic            clk = 1'b0;
  logic            rst;
  logic            input_transmit;
  logic [7:0]      operand;
  logic [1:0][7:0] depvals;
  logic [7:0]      wbs;
  logic [7:0]      flags;
  logic [3:0]      robid;
  logic            cdb_transmit;
  logic            cdb_transmit_out;
  logic [3:0]      cdb_id;
  logic [7:0]      cdb_val;
  logic            rob_transmit;
  logic            rob_transmit_out;
  logic [3:0]      robid_out;
  logic [7:0]      flags_out;
  logic [7:0]      wbs_out;
  logic [7:0]      value_out;
  logic            busy;
  logic [15:0]     sw;
  logic [7:0]      led;

  int checks = 0;
  int errors = 0;

  memfu dut (
    .clk             (clk),
    .rst             (rst),
    .input_transmit  (input_transmit),
    .operand         (operand),
    .depvals         (depvals),
    .wbs             (wbs),
    .flags           (flags),
    .robid           (robid),
    .cdb_transmit    (cdb_transmit),
    .cdb_transmit_out(cdb_transmit_out),
    .cdb_id          (cdb_id),
    .cdb_val         (cdb_val),
    .rob_transmit    (rob_transmit),
    .rob_transmit_out(rob_transmit_out),
    .robid_out       (robid_out),
    .flags_out       (flags_out),
    .wbs_out         (wbs_out),
    .value_out       (value_out),
    .busy            (busy),
    .sw              (sw),
    .led             (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one op at the negedge; it is accepted at the following posedge.
  task automatic drive_op(input bit st, input bit off, input bit nocdb, input logic [7:0] base,
                          input logic [7:0] opnd, input logic [7:0] data, input logic [3:0] id);
    @(negedge clk);
    input_transmit = 1'b1;
    flags          = {nocdb, 4'b0000, off, st, 1'b0};
    depvals[1]     = base;
    depvals[0]     = data;
    operand        = opnd;
    robid          = id;
    wbs            = {4'hA, id};
    @(posedge clk);
    #1;
    input_transmit = 1'b0;
  endtask

  // Full op with grants held high: returns result and cycles from acceptance to first request.
  task automatic run_op(input bit st, input bit off, input bit nocdb, input logic [7:0] base,
                        input logic [7:0] opnd, input logic [7:0] data, input logic [3:0] id,
                        output logic [7:0] val, output int lat);
    int n;
    drive_op(st, off, nocdb, base, opnd, data, id);
    lat = 1;
    while (!rob_transmit_out && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    val = cdb_val;
    check("cdb_req", 32'(cdb_transmit_out), 32'(!nocdb));
    check("cdb_id", 32'(cdb_id), 32'(id));
    check("flags_out", 32'(flags_out), 32'({nocdb, 4'b0000, off, st, 1'b0}));
    check("wbs_out", 32'(wbs_out), 32'({4'hA, id}));
    n = 0;
    while (busy && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("return_idle", 32'(busy), 32'(0));
  endtask

  logic [7:0] val;
  int         lat;

  initial begin
    input_transmit = 1'b0;
    operand        = '0;
    depvals        = '0;
    wbs            = '0;
    flags          = '0;
    robid          = '0;
    cdb_transmit   = 1'b1;
    rob_transmit   = 1'b1;
    sw             = 16'hBEEF;
    rst            = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_cdb_req", 32'(cdb_transmit_out), 32'(0));
    check("rst_rob_req", 32'(rob_transmit_out), 32'(0));
    check("rst_led", 32'(led), 32'(0));
    check("rst_val", 32'(cdb_val), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Store then load the same RAM word
    run_op(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 4'd3, val, lat);
    check("st_lat", 32'(lat), 32'(1));
    check("st_val", 32'(val), 32'(0));
    drive_op(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 4'd5);
    check("ld_busy_rd", 32'(busy), 32'(1));
    check("ld_req_rd", 32'(rob_transmit_out), 32'(0));
    @(posedge clk); #1;
    check("ld_busy_out", 32'(busy), 32'(1));
    check("ld_req_out", 32'(rob_transmit_out), 32'(1));
    check("ld_val", 32'(cdb_val), 32'(8'h5A));
    check("ld_id", 32'(cdb_id), 32'(5));
    @(posedge clk); #1;
    check("ld_done", 32'(busy), 32'(0));

    // Offset addressing wraps: 0xF8 + 0x0A -> 0x02
    run_op(1'b1, 1'b1, 1'b0, 8'hF8, 8'h0A, 8'h33, 4'd6, val, lat);
    run_op(1'b0, 1'b0, 1'b0, 8'h02, 8'h0A, 8'h00, 4'd7, val, lat);
    check("wrap_val", 32'(val), 32'(8'h33));
    check("wrap_lat", 32'(lat), 32'(2));

    // Switch words
    run_op(1'b0, 1'b0, 1'b0, 8'hFE, 8'h00, 8'h00, 4'd1, val, lat);
    check("sw0_val", 32'(val), 32'(8'hEF));
    check("sw0_lat", 32'(lat), 32'(1));
    run_op(1'b0, 1'b1, 1'b0, 8'hF0, 8'h0D, 8'h00, 4'd2, val, lat);
    check("sw1_val", 32'(val), 32'(8'hBE));
    run_op(1'b1, 1'b0, 1'b0, 8'hFE, 8'h00, 8'h11, 4'd3, val, lat);
    check("sw_st_val", 32'(val), 32'(0));
    check("sw_st_led", 32'(led), 32'(0));
    run_op(1'b0, 1'b0, 1'b0, 8'hFE, 8'h00, 8'h00, 4'd4, val, lat);
    check("sw0_again", 32'(val), 32'(8'hEF));

    // LED register
    drive_op(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hA5, 4'd8);
    check("led_write", 32'(led), 32'(8'hA5));
    @(posedge clk); #1;
    check("led_st_idle", 32'(busy), 32'(0));
    run_op(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 4'd9, val, lat);
    check("led_ld_val", 32'(val), 32'(8'hA5));
    check("led_ld_lat", 32'(lat), 32'(1));

    // CDB grant withheld, ROB granted at once
    cdb_transmit = 1'b0;
    drive_op(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 4'd11);
    @(posedge clk); #1;
    check("hold_cdb_req0", 32'(cdb_transmit_out), 32'(1));
    check("hold_rob_req0", 32'(rob_transmit_out), 32'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_rob_drop", 32'(rob_transmit_out), 32'(0));
      check("hold_cdb_req", 32'(cdb_transmit_out), 32'(1));
      check("hold_val", 32'(cdb_val), 32'(8'h5A));
      check("hold_id", 32'(cdb_id), 32'(11));
      check("hold_busy", 32'(busy), 32'(1));
    end
    @(negedge clk);
    cdb_transmit = 1'b1;
    @(posedge clk); #1;
    check("hold_release_req", 32'(cdb_transmit_out), 32'(0));
    check("hold_release_idle", 32'(busy), 32'(0));

    // Suppressed CDB: only the ROB request appears
    run_op(1'b0, 1'b0, 1'b1, 8'h02, 8'h00, 8'h00, 4'd12, val, lat);
    check("nocdb_val", 32'(val), 32'(8'h33));

    // Reset while the RAM read is in flight
    drive_op(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 4'd13);
    check("rd_busy", 32'(busy), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_cdb", 32'(cdb_transmit_out), 32'(0));
    check("mid_rst_rob", 32'(rob_transmit_out), 32'(0));
    check("mid_rst_val", 32'(cdb_val), 32'(0));
    check("mid_rst_led", 32'(led), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 4'd14, val, lat);
    check("post_rst_val", 32'(val), 32'(8'h5A));
    check("post_rst_lat", 32'(lat), 32'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
